hazard_ctrl_unit: RTL and testbench

Parametrised, sequential hazard controller for the 5-stage MIPS pipeline, sitting between the ID stage, the ID/EX and IF/ID registers and the register file read ports. It generalises single-bubble load-use detection to a configurable memory latency, adds a branch-flush sequencer with configurable penalty and a whole-pipe freeze for a busy data memory. It also provides a WB_HIST-deep writeback bypass history that covers register-file writes lost across stalls and flushes.

---
 rtl/hazard_ctrl_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: multi-cycle load-use stall, branch flush sequencer, busy-memory freeze and writeback bypass history
module hazard_ctrl_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int WB_HIST    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_id_instr,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              mem_wb_reg_write,
    input  logic [REG_W-1:0]  mem_wb_rd,
    input  logic [DATA_W-1:0] wb_rdata,
    input  logic [DATA_W-1:0] rs_data_in,
    input  logic [DATA_W-1:0] rt_data_in,
    output logic              pc_write,
    output logic              if_id_write_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              pipe_hold,
    output logic [DATA_W-1:0] rs_data_out,
    output logic [DATA_W-1:0] rt_data_out
);
    localparam int MAXC = (LOAD_LAT > BR_PENALTY) ? LOAD_LAT : BR_PENALTY;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {IDLE, LOAD_STALL, FLUSH} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [WB_HIST-1:0]             hv;
    logic [WB_HIST-1:0][REG_W-1:0]  hr;
    logic [WB_HIST-1:0][DATA_W-1:0] hd;

    logic [5:0]       opcode;
    logic [REG_W-1:0] rs_a, rt_a;
    logic             uses_rt, hit, capture, unused_bits;

    assign opcode      = if_id_instr[31:26];
    assign rs_a        = REG_W'(if_id_instr[25:21]);
    assign rt_a        = REG_W'(if_id_instr[20:16]);
    assign unused_bits = ^if_id_instr[15:0];
    assign uses_rt     = opcode == 6'h00 || opcode == 6'h04 || opcode == 6'h05 || opcode == 6'h2B;
    assign hit         = id_ex_mem_read && id_ex_rt != '0 &&
                         (id_ex_rt == rs_a || (id_ex_rt == rt_a && uses_rt));
    assign capture     = !mem_busy && mem_wb_reg_write && mem_wb_rd != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        pc_write       = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pipe_hold      = 1'b0;
        if (mem_busy) begin
            pipe_hold      = 1'b1;
            pc_write       = 1'b0;
            if_id_write_en = 1'b0;
        end else begin
            case (state)
                LOAD_STALL: begin
                    pc_write       = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_flush    = 1'b1;
                    cnt_n          = cnt - CW'(1);
                    state_n        = (cnt == CW'(1)) ? IDLE : LOAD_STALL;
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    cnt_n       = cnt - CW'(1);
                    state_n     = (cnt == CW'(1)) ? IDLE : FLUSH;
                end
                default: begin
                    if (hit) begin
                        pc_write       = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_n = LOAD_STALL;
                            cnt_n   = CW'(LOAD_LAT - 1);
                        end
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                        if (BR_PENALTY > 1) begin
                            state_n = FLUSH;
                            cnt_n   = CW'(BR_PENALTY - 1);
                        end
                    end
                end
            endcase
        end
    end

    // newest entry lives at index 0; older ones shift up and the last falls off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hv <= '0;
            hr <= '0;
            hd <= '0;
        end else if (capture) begin
            for (int i = WB_HIST - 1; i > 0; i--) begin
                hv[i] <= hv[i-1];
                hr[i] <= hr[i-1];
                hd[i] <= hd[i-1];
            end
            hv[0] <= 1'b1;
            hr[0] <= mem_wb_rd;
            hd[0] <= wb_rdata;
        end
    end

    // scan oldest to newest so the newest match wins; live WB overrides everything
    always_comb begin
        rs_data_out = rs_data_in;
        rt_data_out = rt_data_in;
        for (int i = WB_HIST - 1; i >= 0; i--) begin
            if (hv[i] && rs_a != '0 && hr[i] == rs_a) rs_data_out = hd[i];
            if (hv[i] && rt_a != '0 && hr[i] == rt_a) rt_data_out = hd[i];
        end
        if (mem_wb_reg_write && rs_a != '0 && mem_wb_rd == rs_a) rs_data_out = wb_rdata;
        if (mem_wb_reg_write && rt_a != '0 && mem_wb_rd == rt_a) rt_data_out = wb_rdata;
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks of stall, flush, busy freeze and bypass history
module tb_hazard_ctrl_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_read, br, busy, wb_we;
    logic [4:0]  ex_rt, wb_rd;
    logic [31:0] wb_d, rs_in, rt_in;

    logic        a_pc, a_ifwe, a_iff, a_idf, a_hold;
    logic [31:0] a_rs, a_rt;
    logic        b_pc, b_ifwe, b_iff, b_idf, b_hold;
    logic [31:0] b_rs, b_rt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LOAD_LAT(3), .BR_PENALTY(2), .WB_HIST(2)) u_a (
        .clk(clk), .reset(reset), .if_id_instr(instr), .id_ex_mem_read(mem_read),
        .id_ex_rt(ex_rt), .branch_taken(br), .mem_busy(busy), .mem_wb_reg_write(wb_we),
        .mem_wb_rd(wb_rd), .wb_rdata(wb_d), .rs_data_in(rs_in), .rt_data_in(rt_in),
        .pc_write(a_pc), .if_id_write_en(a_ifwe), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .pipe_hold(a_hold), .rs_data_out(a_rs), .rt_data_out(a_rt)
    );

    hazard_ctrl_unit #(.LOAD_LAT(2), .BR_PENALTY(1), .WB_HIST(1)) u_b (
        .clk(clk), .reset(reset), .if_id_instr(instr), .id_ex_mem_read(mem_read),
        .id_ex_rt(ex_rt), .branch_taken(br), .mem_busy(busy), .mem_wb_reg_write(wb_we),
        .mem_wb_rd(wb_rd), .wb_rdata(wb_d), .rs_data_in(rs_in), .rt_data_in(rt_in),
        .pc_write(b_pc), .if_id_write_en(b_ifwe), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .pipe_hold(b_hold), .rs_data_out(b_rs), .rt_data_out(b_rt)
    );

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        mem_read = 0; ex_rt = 0; br = 0; busy = 0;
        wb_we = 0; wb_rd = 0; wb_d = 0;
        instr = ins(6'h00, 5'd7, 5'd8);
        rs_in = 32'h1234; rt_in = 32'h5678;
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic rst_pulse();
        reset = 1;
        quiet();
        nxt();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        quiet();
        #1;
        chk("rst_pc", a_pc, 1);
        chk("rst_ifwe", a_ifwe, 1);
        chk("rst_iff", a_iff, 0);
        chk("rst_idf", a_idf, 0);
        chk("rst_hold", a_hold, 0);
        chk("rst_rs", a_rs, 32'h1234);
        chk("rst_rt", a_rt, 32'h5678);
        nxt();
        reset = 0;

        // lw $5 in EX, add $6,$5,$1 in ID: three-cycle stall on u_a
        nxt();
        mem_read = 1; ex_rt = 5; instr = ins(6'h00, 5'd5, 5'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lu3_pc", a_pc, 0);
            chk("lu3_idf", a_idf, 1);
            chk("lu3_ifwe", a_ifwe, 0);
            nxt();
        end
        mem_read = 0;
        #1;
        chk("lu3_end_pc", a_pc, 1);
        chk("lu3_end_idf", a_idf, 0);

        // two-cycle stall on u_b stretched by four busy cycles
        rst_pulse();
        mem_read = 1; ex_rt = 5; instr = ins(6'h00, 5'd5, 5'd1);
        #1;
        chk("lu2_c0_pc", b_pc, 0);
        chk("lu2_c0_idf", b_idf, 1);
        nxt();
        busy = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("busy_hold", b_hold, 1);
            chk("busy_idf", b_idf, 0);
            chk("busy_pc", b_pc, 0);
            nxt();
        end
        busy = 0;
        #1;
        chk("lu2_c1_pc", b_pc, 0);
        chk("lu2_c1_idf", b_idf, 1);
        chk("lu2_c1_hold", b_hold, 0);
        nxt();
        mem_read = 0;
        #1;
        chk("lu2_end_pc", b_pc, 1);

        // taken branch: two flush cycles on u_a, one on u_b
        rst_pulse();
        br = 1;
        #1;
        chk("br_c0_iff", a_iff, 1);
        chk("br_c0_pc", a_pc, 1);
        chk("br_c0_ifwe", a_ifwe, 1);
        nxt();
        br = 0;
        #1;
        chk("br_c1_iff", a_iff, 1);
        chk("br_c1_pc", a_pc, 1);
        chk("br_b_c1_iff", b_iff, 0);
        nxt();
        #1;
        chk("br_c2_iff", a_iff, 0);
        br = 1; mem_read = 1; ex_rt = 5; instr = ins(6'h00, 5'd5, 5'd1);
        #1;
        chk("br_vs_lu_iff", a_iff, 0);
        chk("br_vs_lu_idf", a_idf, 1);
        chk("br_vs_lu_pc", a_pc, 0);

        // writeback history across a stall
        rst_pulse();
        rs_in = 0;
        mem_read = 1; ex_rt = 5; instr = ins(6'h00, 5'd7, 5'd5);
        wb_we = 1; wb_rd = 7; wb_d = 32'hA5A5A5A5;
        #1;
        chk("hist_rt_hit", a_idf, 1);
        chk("hist_live1", a_rs, 32'hA5A5A5A5);
        nxt();
        wb_d = 32'h11;
        #1;
        chk("hist_live2", a_rs, 32'h11);
        nxt();
        wb_we = 0;
        #1;
        chk("hist_newest_a", a_rs, 32'h11);
        chk("hist_newest_b", b_rs, 32'h11);
        chk("hist_rt_none", a_rt, 32'h5678);
        nxt();
        wb_we = 1; wb_rd = 0; wb_d = 32'hFF; instr = ins(6'h00, 5'd0, 5'd5);
        #1;
        chk("r0_live", a_rs, 0);
        nxt();
        wb_we = 0;
        #1;
        chk("r0_hist", a_rs, 0);
        mem_read = 0; rs_in = 32'hDEAD;
        wb_we = 1; wb_rd = 9; wb_d = 1;
        nxt();
        wb_rd = 10; wb_d = 2;
        nxt();
        wb_rd = 11; wb_d = 3;
        nxt();
        wb_we = 0; instr = ins(6'h00, 5'd9, 5'd10);
        #1;
        chk("hist_drop", a_rs, 32'hDEAD);
        chk("hist_old", a_rt, 32'h2);
        chk("hist_b_drop", b_rt, 32'h5678);
        busy = 1; wb_we = 1; wb_rd = 12; wb_d = 32'h77;
        nxt();
        busy = 0; wb_we = 0; instr = ins(6'h00, 5'd12, 5'd0);
        #1;
        chk("busy_nocap", a_rs, 32'hDEAD);

        // $0 load never stalls; rt use depends on opcode
        rst_pulse();
        mem_read = 1; ex_rt = 0; instr = ins(6'h00, 5'd0, 5'd0);
        #1;
        chk("rt0_pc", a_pc, 1);
        chk("rt0_idf", a_idf, 0);
        ex_rt = 3; instr = ins(6'h2B, 5'd4, 5'd3);
        #1;
        chk("sw_idf", a_idf, 1);
        chk("sw_pc", a_pc, 0);
        instr = ins(6'h23, 5'd4, 5'd3);
        #1;
        chk("lw_no_rt", a_idf, 0);
        instr = ins(6'h04, 5'd1, 5'd3);
        #1;
        chk("beq_rt", a_idf, 1);
        instr = ins(6'h08, 5'd1, 5'd3);
        #1;
        chk("addi_no_rt", a_pc, 1);

        // async reset aborts a stall with cnt=2 and clears history
        rst_pulse();
        rs_in = 0;
        mem_read = 1; ex_rt = 5; instr = ins(6'h00, 5'd7, 5'd5);
        wb_we = 1; wb_rd = 7; wb_d = 32'hCAFE;
        nxt();
        wb_we = 0; mem_read = 0;
        #1;
        chk("ab_pc", a_pc, 0);
        chk("ab_hist", a_rs, 32'hCAFE);
        reset = 1;
        #1;
        chk("ab_rst_pc", a_pc, 1);
        chk("ab_rst_idf", a_idf, 0);
        chk("ab_rst_ifwe", a_ifwe, 1);
        chk("ab_rst_rs", a_rs, 0);
        nxt();
        reset = 0;
        #1;
        chk("ab_post_pc", a_pc, 1);
        chk("ab_post_rs", a_rs, 0);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
